// File: rtl/max1112x_responder.sv
// SPI responder standing in for a MAX1112x ADC: oversamples the SPI pins, captures
// 16-bit command frames and returns pipelined 16-bit results built from ch_data.
module max1112x_responder #(
  parameter int C_channels = 4,
  parameter int C_chan_id  = 1,
  parameter int C_sync     = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     spi_csn,
  input  logic                     spi_clk,
  input  logic                     spi_mosi,
  output logic                     spi_miso,
  input  logic [C_channels*12-1:0] ch_data,
  output logic [15:0]              cmd,
  output logic                     cmd_dv,
  output logic [15:0]              frame_cnt,
  output logic [7:0]               abort_cnt
);

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, DONE, ABORT} state_t;

  state_t            state;
  logic [C_sync-1:0] csn_sync, sclk_sync, mosi_sync;
  logic              csn_q, sclk_q, csn_pend;
  logic [15:0]       shift_in, shift_out, tx;
  logic [4:0]        bitcnt;
  logic [11:0]       sample;
  logic [3:0]        ch, id;

  wire csn_s     = csn_sync[C_sync-1];
  wire sclk_s    = sclk_sync[C_sync-1];
  wire mosi_s    = mosi_sync[C_sync-1];
  wire csn_fall  = csn_q & ~csn_s;
  wire csn_rise  = ~csn_q & csn_s;
  wire sclk_rise = ~sclk_q & sclk_s;
  wire sclk_fall = sclk_q & ~sclk_s;
  wire adc_conv  = ~shift_in[15] && (shift_in[14:11] != 4'h0);

  assign ch = shift_in[10:7];
  assign id = (C_chan_id != 0) ? ch : 4'h0;

  // Channel select; unpopulated channels read as zero.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    sample = 12'h000;
    for (int i = 0; i < C_channels; i++)
      if (ch == 4'(i)) sample = ch_data[i*12 +: 12];
  end

  // NOTE: all state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csn_sync  <= '1;
      sclk_sync <= '0;
      mosi_sync <= '0;
      csn_q     <= 1'b1;
      sclk_q    <= 1'b0;
      csn_pend  <= 1'b0;
      state     <= IDLE;
      spi_miso  <= 1'b0;
      shift_in  <= 16'h0000;
      shift_out <= 16'h0000;
      tx        <= 16'h0000;
      bitcnt    <= 5'd0;
      cmd       <= 16'h0000;
      cmd_dv    <= 1'b0;
      frame_cnt <= 16'h0000;
      abort_cnt <= 8'h00;
    end else begin
      csn_sync  <= {csn_sync[C_sync-2:0], spi_csn};
      sclk_sync <= {sclk_sync[C_sync-2:0], spi_clk};
      mosi_sync <= {mosi_sync[C_sync-2:0], spi_mosi};
      csn_q     <= csn_s;
      sclk_q    <= sclk_s;
      cmd_dv    <= 1'b0;

      case (state)
        IDLE: begin
          spi_miso <= 1'b0;
          csn_pend <= 1'b0;
          if (csn_fall || csn_pend) state <= LOAD;
        end
        LOAD: begin
          shift_out <= tx;
          bitcnt    <= 5'd0;
          spi_miso  <= csn_rise ? 1'b0 : tx[15];
          state     <= csn_rise ? ABORT : SHIFT;
        end
        SHIFT: begin
          if (csn_rise) begin
            spi_miso <= 1'b0;
            state    <= (bitcnt == 5'd16) ? DONE : ABORT;
          end else if (sclk_rise) begin
            shift_in <= {shift_in[14:0], mosi_s};
            if (bitcnt != 5'd16) bitcnt <= bitcnt + 5'd1;
          end else if (sclk_fall) begin
            shift_out <= {shift_out[14:0], 1'b0};
            spi_miso  <= (bitcnt == 5'd16) ? 1'b0 : shift_out[14];
          end
        end
        DONE: begin
          cmd       <= shift_in;
          cmd_dv    <= 1'b1;
          frame_cnt <= frame_cnt + 16'd1;
          if (adc_conv) tx <= {id, sample};
          if (csn_fall) csn_pend <= 1'b1;
          state     <= IDLE;
        end
        ABORT: begin
          if (abort_cnt != 8'hFF) abort_cnt <= abort_cnt + 8'd1;
          if (csn_fall) csn_pend <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
